// File: rtl/link_monitor_mc_pkg.sv
// Shared link monitor codes: status, control and state encodings.
// Also provides the per-channel timer width helper.
package link_monitor_mc_pkg;

  localparam logic OK      = 1'b0;
  localparam logic NOT_OK  = 1'b1;
  localparam logic FAIL    = 1'b1;
  localparam logic ENABLE  = 1'b0;
  localparam logic DISABLE = 1'b1;

  typedef enum logic [1:0] {
    LINK_DOWN    = 2'd0,
    LINK_PENDING = 2'd1,
    LINK_UP      = 2'd2,
    LINK_HOLD    = 2'd3
  } link_state_e;

  function automatic int timer_width(int s, int h);
    int m;
    m = (s > h) ? s : h;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/link_monitor_mc_if.sv
// Multi-channel link monitor bus.
// master drives receive status/control, slave is the monitor.
interface link_monitor_mc_if #(
  parameter int NUM_CH     = 4,
  parameter int FAIL_CNT_W = 8
);
  logic [NUM_CH-1:0]            pma_reset;
  logic [NUM_CH-1:0]            link_control;
  logic [NUM_CH-1:0]            pcs_status;
  logic [NUM_CH-1:0]            loc_rcv_status;
  logic [NUM_CH-1:0]            fail_cnt_clr;
  logic [NUM_CH-1:0]            link_status;
  logic [2*NUM_CH-1:0]          link_state;
  logic [NUM_CH-1:0]            link_change;
  logic [FAIL_CNT_W*NUM_CH-1:0] fail_cnt;
  logic                         any_link_up;
  logic                         all_link_up;

  modport master (
    output pma_reset, link_control, pcs_status,
    output loc_rcv_status, fail_cnt_clr,
    input  link_status, link_state, link_change,
    input  fail_cnt, any_link_up, all_link_up
  );

  modport slave (
    input  pma_reset, link_control, pcs_status,
    input  loc_rcv_status, fail_cnt_clr,
    output link_status, link_state, link_change,
    output fail_cnt, any_link_up, all_link_up
  );
endinterface

// File: rtl/link_monitor_mc_ch.sv
// Single-channel link monitor: qualify/hold-off FSM,
// shared timer and saturating link-fail counter.
module link_monitor_ch
  import link_monitor_mc_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int HOLD_CYCLES   = 8,
  parameter int FAIL_CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pma_reset,
  input  logic                  i_link_control,
  input  logic                  i_pcs_status,
  input  logic                  i_loc_rcv_status,
  input  logic                  i_fail_cnt_clr,
  output logic                  o_link_status,
  output logic [1:0]            o_link_state,
  output logic                  o_link_change,
  output logic [FAIL_CNT_W-1:0] o_fail_cnt,
  output logic                  o_next_ok
);
  localparam int TW = timer_width(STABLE_CYCLES, HOLD_CYCLES);
  localparam logic [TW-1:0] STB_END = TW'(STABLE_CYCLES);
  localparam logic [TW-1:0] HLD_END = TW'(HOLD_CYCLES);

  link_state_e           r_state, w_nstate;
  logic [TW-1:0]         r_timer, w_ntimer;
  logic                  r_status, r_change;
  logic [FAIL_CNT_W-1:0] r_fail;
  logic                  w_good, w_force;
  logic                  w_fail_evt, w_nstatus;

  assign w_good  = (i_pcs_status == OK) && i_loc_rcv_status;
  assign w_force = i_pma_reset || (i_link_control == DISABLE);

  // Next state, timer and natural-failure detection
  always_comb begin
    w_nstate   = r_state;
    w_ntimer   = r_timer;
    w_fail_evt = 1'b0;
    if (w_force) begin
      w_nstate = LINK_DOWN;
      w_ntimer = '0;
    end else begin
      unique case (r_state)
        LINK_DOWN: begin
          if (w_good) begin
            w_nstate = LINK_PENDING;
            w_ntimer = TW'(1);
          end
        end
        LINK_PENDING: begin
          if (!w_good) begin
            w_nstate = LINK_DOWN;
            w_ntimer = '0;
          end else if (r_timer == STB_END) begin
            w_nstate = LINK_UP;
            w_ntimer = '0;
          end else begin
            w_ntimer = r_timer + TW'(1);
          end
        end
        LINK_UP: begin
          if (!w_good) begin
            w_nstate = LINK_HOLD;
            w_ntimer = TW'(1);
          end
        end
        LINK_HOLD: begin
          if (w_good) begin
            w_nstate = LINK_UP;
            w_ntimer = '0;
          end else if (r_timer == HLD_END) begin
            w_nstate   = LINK_DOWN;
            w_ntimer   = '0;
            w_fail_evt = 1'b1;
          end else begin
            w_ntimer = r_timer + TW'(1);
          end
        end
        default: begin
          w_nstate = LINK_DOWN;
          w_ntimer = '0;
        end
      endcase
    end
  end

  assign w_nstatus = ((w_nstate == LINK_UP) ||
                      (w_nstate == LINK_HOLD)) ? OK : FAIL;

  // State, timer, registered status/change and fail counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= LINK_DOWN;
      r_timer  <= '0;
      r_status <= FAIL;
      r_change <= 1'b0;
      r_fail   <= '0;
    end else begin
      r_state  <= w_nstate;
      r_timer  <= w_ntimer;
      r_status <= w_nstatus;
      r_change <= (w_nstatus != r_status);
      if (i_fail_cnt_clr)
        r_fail <= '0;
      else if (w_fail_evt && (r_fail != '1))
        r_fail <= r_fail + FAIL_CNT_W'(1);
    end
  end

  assign o_link_status = r_status;
  assign o_link_state  = r_state;
  assign o_link_change = r_change;
  assign o_fail_cnt    = r_fail;
  assign o_next_ok     = (w_nstatus == OK);

`ifdef simulate
  logic [8*7-1:0] w_state_ascii;
  // Readable state name for waveform viewing
  always_comb begin
    unique case (r_state)
      LINK_DOWN:    w_state_ascii = "DOWN";
      LINK_PENDING: w_state_ascii = "PENDING";
      LINK_UP:      w_state_ascii = "UP";
      LINK_HOLD:    w_state_ascii = "HOLD";
      default:      w_state_ascii = "???";
    endcase
  end
`endif

endmodule

// File: rtl/link_monitor_mc.sv
// Multi-channel link monitor top: one channel FSM per port
// plus registered any/all link-up summaries.
module link_monitor_mc
  import link_monitor_mc_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int HOLD_CYCLES   = 8,
  parameter int FAIL_CNT_W    = 8
) (
  input logic              clk,
  input logic              reset,
  link_monitor_mc_if.slave mon
);
  logic [NUM_CH-1:0]            w_next_ok;
  logic [NUM_CH-1:0]            w_status;
  logic [2*NUM_CH-1:0]          w_state;
  logic [NUM_CH-1:0]            w_change;
  logic [FAIL_CNT_W*NUM_CH-1:0] w_fail;
  logic                         r_any, r_all;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    link_monitor_ch #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .FAIL_CNT_W   (FAIL_CNT_W)
    ) u_ch (
      .clk             (clk),
      .rst             (reset),
      .i_pma_reset     (mon.pma_reset[g]),
      .i_link_control  (mon.link_control[g]),
      .i_pcs_status    (mon.pcs_status[g]),
      .i_loc_rcv_status(mon.loc_rcv_status[g]),
      .i_fail_cnt_clr  (mon.fail_cnt_clr[g]),
      .o_link_status   (w_status[g]),
      .o_link_state    (w_state[2*g +: 2]),
      .o_link_change   (w_change[g]),
      .o_fail_cnt      (w_fail[FAIL_CNT_W*g +: FAIL_CNT_W]),
      .o_next_ok       (w_next_ok[g])
    );
  end

  // Summaries taken from next status so they track link_status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_any <= 1'b0;
      r_all <= 1'b0;
    end else begin
      r_any <= |w_next_ok;
      r_all <= &w_next_ok;
    end
  end

  assign mon.link_status = w_status;
  assign mon.link_state  = w_state;
  assign mon.link_change = w_change;
  assign mon.fail_cnt    = w_fail;
  assign mon.any_link_up = r_any;
  assign mon.all_link_up = r_all;

endmodule
